pkt_wrr_sched: RTL
==================

# pkt_wrr_sched

Weighted-round-robin packet scheduler for the egress side of one switch port. It chooses one packet descriptor per grant from QUEUE_NUM per-priority descriptor queues and presents it to the packet read unit on its first-address handshake. It then waits for that packet (normal read or drop) to finish before it issues the next descriptor. The block sequences the single shared read/MMU datapath between the port's queues.

## Interface
- ADDR_LENTH, 12, block address width.
- QUEUE_NUM, 4, number of descriptor queues (2..8).
- WEIGHT_W, 4, per-queue weight/credit width.
- iClk  in  1  single clock.
- iRst_n  in  1  asynchronous active-low reset.
- iQueDescVld  in  QUEUE_NUM  queue q head descriptor valid (queue non-empty).
- iQueDesc  in  QUEUE_NUM*(ADDR_LENTH+5)  per queue {drop[1], blocknum[4], firaddr[ADDR_LENTH]}, queue 0 in LSBs; head stable until popped.
- oQuePop  out  QUEUE_NUM  one-cycle one-hot pop of the granted head.
- iWeight  in  QUEUE_NUM*WEIGHT_W  packets per round per queue; 0 = queue disabled.
- oPktFirAddr  out  ADDR_LENTH  granted packet first block address.
- oBlockNum  out  4  granted packet block count code.
- oPktDrop  out  1  granted packet is to be dropped.
- oPktFirAddrVld  out  1  descriptor valid.
- iPktFirAddrRdy  in  1  read unit accepts descriptor.
- iPktDone  in  1  one-cycle pulse: current packet finished (last data handshake, or drop completion).
- oGrantQue  out  $clog2(QUEUE_NUM)  queue index of current/last grant.
- oBusy  out  1  packet in flight (ISSUE or WAIT).

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- Per-queue credit counters rCredit[q] (WEIGHT_W bits) and search pointer rPtr.
- Eligible[q] = iQueDescVld[q] & rCredit[q] != 0.
- IDLE, any eligible: grant the first eligible queue, searching cyclically from rPtr inclusive. Latch its descriptor into the outputs, set rPtr and oGrantQue to q, and go to ISSUE. A queue therefore keeps the grant until its credit reaches 0 or it empties; the grant then moves to the next queue in cyclic order.
- IDLE, none eligible, but some q has iQueDescVld & iWeight[q] != 0: reload every rCredit[q] <= iWeight[q] (new round) and stay in IDLE. iWeight is sampled only at a reload.
- IDLE, otherwise: hold.
- ISSUE: oPktFirAddrVld=1 with stable outputs. On iPktFirAddrRdy: pulse oQuePop[q], decrement rCredit[q], drop oPktFirAddrVld, go to WAIT.
- WAIT: on iPktDone go to IDLE. iPktDone outside WAIT is ignored.
- Drop descriptors are scheduled exactly like normal ones and consume credit.

## Timing
- Reset values: all outputs 0, state IDLE, rCredit all 0, rPtr 0.
- Because credits reset to 0, the first request after reset costs one reload cycle.
- Select cycle t (IDLE) -> oPktFirAddrVld high at t+1.
- Handshake at cycle h -> oQuePop pulse at h (combinational from handshake in ISSUE). Credit is updated at h+1.
- iPktDone at cycle d -> IDLE at d+1. Earliest next oPktFirAddrVld is d+2 (d+3 if a reload is needed).
- Valid never deasserts without ready. Descriptor outputs change only in the IDLE->ISSUE transition.
- Credit never underflows: decrement happens only on a grant with credit != 0.
- Reset mid-ISSUE/WAIT: return to reset state and issue no pop. The queue keeps its head.
- Queue empties between reload and selection: it is simply not eligible and its credit is kept until the next reload.

## Configuration
- WRR_SP_EN defined: queue QUEUE_NUM-1 is strict priority.
  - In IDLE, iQueDescVld[QUEUE_NUM-1] wins regardless of credit or rPtr.
  - Its grants do not decrement credit and do not move rPtr.
  - Its iWeight is ignored, except that weight 0 still disables it.
  - Remaining queues run WRR as above.
- WRR_SP_EN undefined: all QUEUE_NUM queues are pure WRR.

## Test plan
- Weights {1,2,3,4} (q0..q3), all queues kept full, rdy=1, done 5 cycles after each pop -> per round grant order q0,q1,q1,q2,q2,q2,q3,q3,q3,q3, repeating.
- Only q2 valid, weight 2, 5 packets -> grants q2 ×2, reload cycle, q2 ×2, reload, q2 ×1. No pops on other queues.
- iPktFirAddrRdy held 0 for 7 cycles in ISSUE -> valid held high, oPktFirAddr/oBlockNum/oPktDrop unchanged, no pop until rdy.
- q1 head {drop=1, blocknum=3, addr=0x0A5}, weight 1 -> outputs exactly 0x0A5/3/1. The next grant waits for iPktDone. iPktDone pulsed during ISSUE is ignored.
- iRst_n asserted in WAIT with credits {2,1,0,3} -> all outputs 0, credits 0. After release, the first grant comes after one reload cycle.
- WRR_SP_EN: q3 goes valid while q0 has credit 3 -> q3 granted at the next IDLE, q0 credit unchanged. WRR resumes at q0 once q3 is empty.

Source files
------------

// File: rtl/pkt_wrr_sched_if.sv
// rtl/pkt_wrr_sched_if.sv - descriptor queue, weight and read-unit handshake bundle for pkt_wrr_sched
interface pkt_wrr_sched_if #(
   parameter int ADDR_LENTH = 12,
   parameter int QUEUE_NUM  = 4,
   parameter int WEIGHT_W   = 4
);
   localparam int GW = $clog2(QUEUE_NUM);
   localparam int DW = ADDR_LENTH + 5;

   // Queue heads: per queue {drop, blocknum[3:0], firaddr}, queue 0 in the LSBs
   logic [QUEUE_NUM-1:0]          iQueDescVld;
   logic [QUEUE_NUM*DW-1:0]       iQueDesc;
   logic [QUEUE_NUM-1:0]          oQuePop;
   logic [QUEUE_NUM*WEIGHT_W-1:0] iWeight;

   // Read unit first-address handshake and completion
   logic [ADDR_LENTH-1:0]         oPktFirAddr;
   logic [3:0]                    oBlockNum;
   logic                          oPktDrop;
   logic                          oPktFirAddrVld;
   logic                          iPktFirAddrRdy;
   logic                          iPktDone;

   // Status
   logic [GW-1:0]                 oGrantQue;
   logic                          oBusy;

   // Scheduler side
   modport master (
      input  iQueDescVld, iQueDesc, iWeight, iPktFirAddrRdy, iPktDone,
      output oQuePop, oPktFirAddr, oBlockNum, oPktDrop, oPktFirAddrVld, oGrantQue, oBusy
   );

   // Queue manager / read unit side
   modport slave (
      output iQueDescVld, iQueDesc, iWeight, iPktFirAddrRdy, iPktDone,
      input  oQuePop, oPktFirAddr, oBlockNum, oPktDrop, oPktFirAddrVld, oGrantQue, oBusy
   );
endinterface

// File: rtl/pkt_wrr_sched.sv
// rtl/pkt_wrr_sched.sv - weighted-round-robin egress descriptor scheduler; WRR_SP_EN makes the top queue strict priority
module pkt_wrr_sched #(
   parameter int ADDR_LENTH = 12,
   parameter int QUEUE_NUM  = 4,
   parameter int WEIGHT_W   = 4
) (
   input logic             iClk,
   input logic             iRst_n,
   pkt_wrr_sched_if.master bus
);
   localparam int GW = $clog2(QUEUE_NUM);
   localparam int DW = ADDR_LENTH + 5;
   localparam logic [GW-1:0] LAST_Q = GW'(QUEUE_NUM - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [WEIGHT_W-1:0]   credit_q [QUEUE_NUM];
   logic [WEIGHT_W-1:0]   credit_d [QUEUE_NUM];
   logic [GW-1:0]         ptr_q, ptr_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic [ADDR_LENTH-1:0] addr_q, addr_d;
   logic [3:0]            blk_q, blk_d;
   logic                  drop_q, drop_d;
   logic                  vld_q, vld_d;
   logic                  busy_q, busy_d;

   logic [WEIGHT_W-1:0]   weight [QUEUE_NUM];
   logic [QUEUE_NUM-1:0]  eligible;
   logic [QUEUE_NUM-1:0]  reloadable;
   logic                  reload_ok;
   logic                  sel_found;
   logic [GW-1:0]         sel_idx;
   int                    sel_pos;
   logic                  sp_req;
   logic                  grant_is_sp;
   logic                  take;
   logic [GW-1:0]         take_idx;
   logic [DW-1:0]         take_desc;
   logic [GW-1:0]         next_q;
   logic                  handshake;

   // Split the weight bus and qualify every queue for WRR selection and for a round reload
   always_comb begin
      for (int q = 0; q < QUEUE_NUM; q++) begin
         weight[q]     = bus.iWeight[q*WEIGHT_W +: WEIGHT_W];
         eligible[q]   = bus.iQueDescVld[q] & (credit_q[q] != '0);
         reloadable[q] = bus.iQueDescVld[q] & (bus.iWeight[q*WEIGHT_W +: WEIGHT_W] != '0);
      end
`ifdef WRR_SP_EN
      // The strict-priority queue never competes in the weighted rotation
      eligible[QUEUE_NUM-1]   = 1'b0;
      reloadable[QUEUE_NUM-1] = 1'b0;
`endif
   end

   assign reload_ok = |reloadable;

`ifdef WRR_SP_EN
   assign sp_req      = bus.iQueDescVld[QUEUE_NUM-1] & (weight[QUEUE_NUM-1] != '0);
   assign grant_is_sp = (grant_q == LAST_Q);
`else
   assign sp_req      = 1'b0;
   assign grant_is_sp = 1'b0;
`endif

   // Cyclic first-eligible search starting at the pointer; scanning offsets downward leaves the nearest hit
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_pos   = 0;
      for (int k = QUEUE_NUM - 1; k >= 0; k--) begin
         sel_pos = int'(ptr_q) + k;
         if (sel_pos >= QUEUE_NUM) begin
            sel_pos = sel_pos - QUEUE_NUM;
         end
         if (eligible[sel_pos]) begin
            sel_found = 1'b1;
            sel_idx   = GW'(sel_pos);
         end
      end
   end

   assign take      = sp_req | sel_found;
   assign take_idx  = sp_req ? LAST_Q : sel_idx;
   assign take_desc = bus.iQueDesc[int'(take_idx)*DW +: DW];
   assign next_q    = (grant_q == LAST_Q) ? '0 : GW'(grant_q + 1'b1);
   assign handshake = (state_q == ISSUE) & bus.iPktFirAddrRdy;

   // Next-state: select or reload in IDLE, consume credit on the handshake, wait for packet completion
   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      addr_d   = addr_q;
      blk_d    = blk_q;
      drop_d   = drop_q;
      vld_d    = vld_q;
      busy_d   = busy_q;
      case (state_q)
         IDLE: begin
            if (take) begin
               grant_d = take_idx;
               if (!sp_req) begin
                  ptr_d = take_idx;
               end
               addr_d  = take_desc[ADDR_LENTH-1:0];
               blk_d   = take_desc[ADDR_LENTH +: 4];
               drop_d  = take_desc[ADDR_LENTH+4];
               vld_d   = 1'b1;
               busy_d  = 1'b1;
               state_d = ISSUE;
            end else if (reload_ok) begin
               for (int q = 0; q < QUEUE_NUM; q++) begin
                  credit_d[q] = weight[q];
               end
            end
         end
         ISSUE: begin
            if (bus.iPktFirAddrRdy) begin
               vld_d   = 1'b0;
               state_d = WAIT;
               for (int q = 0; q < QUEUE_NUM; q++) begin
                  if (!grant_is_sp && (grant_q == GW'(q)) && (credit_q[q] != '0)) begin
                     credit_d[q] = credit_q[q] - WEIGHT_W'(1);
                     // Spending the last credit hands the rotation to the next queue in cyclic order
                     if (credit_q[q] == WEIGHT_W'(1)) begin
                        ptr_d = next_q;
                     end
                  end
               end
            end
         end
         WAIT: begin
            if (bus.iPktDone) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, credits, pointer and registered descriptor outputs
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= IDLE;
         for (int q = 0; q < QUEUE_NUM; q++) begin
            credit_q[q] <= '0;
         end
         ptr_q   <= '0;
         grant_q <= '0;
         addr_q  <= '0;
         blk_q   <= '0;
         drop_q  <= 1'b0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         addr_q   <= addr_d;
         blk_q    <= blk_d;
         drop_q   <= drop_d;
         vld_q    <= vld_d;
         busy_q   <= busy_d;
      end
   end

   // Pop is the handshake itself, so it cannot fire once reset has pulled the state back to IDLE
   assign bus.oQuePop        = handshake ? (QUEUE_NUM'(1) << grant_q) : '0;
   assign bus.oPktFirAddr    = addr_q;
   assign bus.oBlockNum      = blk_q;
   assign bus.oPktDrop       = drop_q;
   assign bus.oPktFirAddrVld = vld_q;
   assign bus.oGrantQue      = grant_q;
   assign bus.oBusy          = busy_q;
endmodule
